// File: rtl/ps2_tx_if.sv
// Host-side handshake bundle for the PS/2 transmitter: start strobe and byte in,
// idle/done/error status out. The open-collector lines stay plain module ports.
interface ps2_tx_if;
    logic       wr_ps2_i;
    logic [7:0] din_i;
    logic       rx_idle_i;
    logic       tx_idle_o;
    logic       tx_done_tick_o;
    logic       ack_err_o;

    modport master (
        output wr_ps2_i, din_i, rx_idle_i,
        input  tx_idle_o, tx_done_tick_o, ack_err_o
    );

    modport slave (
        input  wr_ps2_i, din_i, rx_idle_i,
        output tx_idle_o, tx_done_tick_o, ack_err_o
    );
endinterface

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, start/8 data/odd parity/stop,
// device ack sampling, and a watchdog that aborts a frame the device never clocks.
module ps2_tx #(
    parameter int RTS_CYCLES     = 12000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic     clk_i,
    input  logic     reset_i,
    ps2_tx_if.slave  bus,
    inout  wire      ps2d_io,
    inout  wire      ps2c_io
);

    localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RTS   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            c_sync_q, c_sync_d;
    logic [1:0]            d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            n_q, n_d;
    logic [8:0]            shift_q, shift_d;
    logic                  c_drv_q, c_drv_d;
    logic                  d_drv_q, d_drv_d;
    logic                  tx_idle_q, tx_idle_d;
    logic                  done_q, done_d;
    logic                  ack_err_q, ack_err_d;
    logic                  fall_tick_s;
    logic                  wd_expired_s;

    // Synchronizers and clock glitch filter; the filtered clock only moves on a full run of equal samples.
    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c_io};
        d_sync_d = {d_sync_q[0], ps2d_io};
        filt_d   = {c_sync_q[1], filt_q[FILTER_LEN-1:1]};
        if (filt_q == {FILTER_LEN{1'b1}}) begin
            fclk_d = 1'b1;
        end else if (filt_q == {FILTER_LEN{1'b0}}) begin
            fclk_d = 1'b0;
        end else begin
            fclk_d = fclk_q;
        end
        fall_tick_s = fclk_q & (filt_q == {FILTER_LEN{1'b0}});
    end

    // Frame sequencing; one counter serves as RTS timer and, from START onward, as watchdog.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        n_d          = n_q;
        shift_d      = shift_q;
        done_d       = 1'b0;
        ack_err_d    = ack_err_q;
        wd_expired_s = ((state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP)) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        if (wd_expired_s) begin
            state_d   = S_IDLE;
            ack_err_d = 1'b1;
            done_d    = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = {CNT_W{1'b0}};
                    if (bus.wr_ps2_i && bus.rx_idle_i) begin
                        shift_d   = {odd_parity(bus.din_i), bus.din_i};
                        n_d       = 4'd0;
                        ack_err_d = 1'b0;
                        state_d   = S_RTS;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RTS: begin
                    if (cnt_q == CNT_W'(RTS_CYCLES - 1)) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = S_START;
                    end else begin
                        state_d = S_RTS;
                    end
                end
                S_START: begin
                    if (fall_tick_s) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_START;
                    end
                end
                S_DATA: begin
                    if (fall_tick_s && (n_q == 4'd8)) begin
                        state_d = S_STOP;
                    end else if (fall_tick_s) begin
                        shift_d = {1'b0, shift_q[8:1]};
                        n_d     = n_q + 4'd1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_STOP: begin
                    if (fall_tick_s) begin
                        ack_err_d = d_sync_q[1];
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Line drives and idle flag follow the next state so they register together with it.
    always_comb begin
        c_drv_d   = (state_d == S_RTS);
        d_drv_d   = (state_d == S_START) || ((state_d == S_DATA) && !shift_d[0]);
        tx_idle_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            c_sync_q  <= 2'b11;
            d_sync_q  <= 2'b11;
            filt_q    <= {FILTER_LEN{1'b1}};
            fclk_q    <= 1'b1;
            cnt_q     <= {CNT_W{1'b0}};
            n_q       <= 4'd0;
            shift_q   <= 9'd0;
            c_drv_q   <= 1'b0;
            d_drv_q   <= 1'b0;
            tx_idle_q <= 1'b1;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_sync_q  <= c_sync_d;
            d_sync_q  <= d_sync_d;
            filt_q    <= filt_d;
            fclk_q    <= fclk_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            shift_q   <= shift_d;
            c_drv_q   <= c_drv_d;
            d_drv_q   <= d_drv_d;
            tx_idle_q <= tx_idle_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign ps2c_io            = c_drv_q ? 1'b0 : 1'bz;
    assign ps2d_io            = d_drv_q ? 1'b0 : 1'bz;
    assign bus.tx_idle_o      = tx_idle_q;
    assign bus.tx_done_tick_o = done_q;
    assign bus.ack_err_o      = ack_err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a behavioural PS/2 device clocking the frame.
module tb_ps2_tx;

    logic clk;
    logic reset_i;
    logic dev_c;
    logic dev_d;
    wire  ps2c;
    wire  ps2d;
    int   total;
    int   bad;
    int   done_cnt;

    ps2_tx_if bus();

    ps2_tx #(
        .RTS_CYCLES    (100),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(20000)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (bus),
        .ps2d_io(ps2d),
        .ps2c_io(ps2c)
    );

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tx_done_tick_o === 1'b1) done_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] b);
        bus.din_i    = b;
        bus.wr_ps2_i = 1'b1;
        cyc(1);
        bus.wr_ps2_i = 1'b0;
    endtask

    // Counts host-held clock-low cycles; returns in the first START cycle.
    task automatic measure_rts(output int len);
        len = 0;
        while (ps2c === 1'b0 && len < 1000) begin
            len++;
            cyc(1);
        end
    endtask

    // Device: samples start before fall 1, then on each rising edge; optional ack, strobe, glitch.
    task automatic device_clock(input int npulses, input bit ack, input int strobe_k,
                                input int glitch_k, output logic [10:0] fr);
        fr = 11'd0;
        cyc(50);
        fr[0] = ps2d;
        for (int k = 1; k <= npulses; k++) begin
            if (k == 11 && ack) begin
                dev_d = 1'b1;
                cyc(5);
            end
            dev_c = 1'b1;
            cyc(50);
            dev_c = 1'b0;
            if (k <= 10) fr[k] = ps2d;
            if (k == 11) dev_d = 1'b0;
            if (k == strobe_k) begin
                bus.din_i    = 8'hFF;
                bus.wr_ps2_i = 1'b1;
                cyc(1);
                bus.wr_ps2_i = 1'b0;
                cyc(49);
            end else if (k == glitch_k) begin
                cyc(20);
                dev_c = 1'b1;
                cyc(4);
                dev_c = 1'b0;
                cyc(26);
            end else begin
                cyc(50);
            end
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        cyc(3);
        total++; if (bus.tx_idle_o !== 1'b1) begin bad++; $display("FAIL reset_idle: got=%b want=1", bus.tx_idle_o); end
        total++; if (bus.tx_done_tick_o !== 1'b0) begin bad++; $display("FAIL reset_done: got=%b want=0", bus.tx_done_tick_o); end
        total++; if (bus.ack_err_o !== 1'b0) begin bad++; $display("FAIL reset_ackerr: got=%b want=0", bus.ack_err_o); end
        total++; if (ps2c !== 1'b1) begin bad++; $display("FAIL reset_ps2c: got=%b want=released", ps2c); end
        total++; if (ps2d !== 1'b1) begin bad++; $display("FAIL reset_ps2d: got=%b want=released", ps2d); end
        reset_i = 1'b0;
        cyc(2);
    endtask

    task automatic test_normal_ack;
        int len;
        int d0;
        logic [10:0] fr;
        d0 = done_cnt;
        accept(8'hF4);
        total++; if (bus.tx_idle_o !== 1'b0) begin bad++; $display("FAIL accept_idle: got=%b want=0", bus.tx_idle_o); end
        total++; if (ps2c !== 1'b0) begin bad++; $display("FAIL accept_ps2c: got=%b want=0", ps2c); end
        measure_rts(len);
        total++; if (len != 100) begin bad++; $display("FAIL rts_len: got=%0d want=100", len); end
        device_clock(11, 1'b1, 0, 0, fr);
        cyc(20);
        total++; if (fr !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin bad++; $display("FAIL frame_f4: got=%b want=%b", fr, {1'b1, 1'b0, 8'hF4, 1'b0}); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL done_f4: got=%0d want=1", done_cnt - d0); end
        total++; if (bus.ack_err_o !== 1'b0) begin bad++; $display("FAIL ackerr_f4: got=%b want=0", bus.ack_err_o); end
        total++; if (bus.tx_idle_o !== 1'b1) begin bad++; $display("FAIL idle_f4: got=%b want=1", bus.tx_idle_o); end
    endtask

    task automatic test_missing_ack;
        int len;
        int d0;
        logic [10:0] fr;
        d0 = done_cnt;
        accept(8'h00);
        measure_rts(len);
        device_clock(11, 1'b0, 0, 0, fr);
        cyc(20);
        total++; if (fr !== {1'b1, 1'b1, 8'h00, 1'b0}) begin bad++; $display("FAIL frame_00: got=%b want=%b", fr, {1'b1, 1'b1, 8'h00, 1'b0}); end
        total++; if (bus.ack_err_o !== 1'b1) begin bad++; $display("FAIL ackerr_noack: got=%b want=1", bus.ack_err_o); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL done_noack: got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_timeout;
        int len;
        int cnt;
        accept(8'hA5);
        measure_rts(len);
        cnt = 0;
        while (bus.tx_done_tick_o !== 1'b1 && cnt < 30000) begin
            cyc(1);
            cnt++;
        end
        total++; if (cnt != 20000) begin bad++; $display("FAIL timeout_len: got=%0d want=20000", cnt); end
        total++; if (bus.ack_err_o !== 1'b1) begin bad++; $display("FAIL timeout_ackerr: got=%b want=1", bus.ack_err_o); end
        total++; if (ps2c !== 1'b1) begin bad++; $display("FAIL timeout_ps2c: got=%b want=released", ps2c); end
        total++; if (ps2d !== 1'b1) begin bad++; $display("FAIL timeout_ps2d: got=%b want=released", ps2d); end
        total++; if (bus.tx_idle_o !== 1'b1) begin bad++; $display("FAIL timeout_idle: got=%b want=1", bus.tx_idle_o); end
        cyc(5);
    endtask

    task automatic test_blocked_strobes;
        int len;
        int d0;
        logic [10:0] fr;
        d0 = done_cnt;
        accept(8'h5A);
        measure_rts(len);
        device_clock(11, 1'b1, 3, 0, fr);
        cyc(300);
        total++; if (fr !== {1'b1, 1'b1, 8'h5A, 1'b0}) begin bad++; $display("FAIL frame_strobe: got=%b want=%b", fr, {1'b1, 1'b1, 8'h5A, 1'b0}); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL done_strobe: got=%0d want=1", done_cnt - d0); end
        total++; if (bus.tx_idle_o !== 1'b1) begin bad++; $display("FAIL no_extra_frame: got=%b want=1", bus.tx_idle_o); end
        bus.rx_idle_i = 1'b0;
        accept(8'hF4);
        total++; if (bus.tx_idle_o !== 1'b1) begin bad++; $display("FAIL rxbusy_idle: got=%b want=1", bus.tx_idle_o); end
        total++; if (ps2c !== 1'b1) begin bad++; $display("FAIL rxbusy_ps2c: got=%b want=released", ps2c); end
        cyc(5);
        bus.rx_idle_i = 1'b1;
        cyc(5);
        total++; if (bus.tx_idle_o !== 1'b1) begin bad++; $display("FAIL rxbusy_not_queued: got=%b want=1", bus.tx_idle_o); end
    endtask

    task automatic test_glitch_and_reset;
        int len;
        logic [10:0] fr;
        accept(8'h3C);
        measure_rts(len);
        device_clock(11, 1'b1, 0, 4, fr);
        cyc(20);
        total++; if (fr !== {1'b1, 1'b1, 8'h3C, 1'b0}) begin bad++; $display("FAIL frame_glitch: got=%b want=%b", fr, {1'b1, 1'b1, 8'h3C, 1'b0}); end
        total++; if (bus.ack_err_o !== 1'b0) begin bad++; $display("FAIL ackerr_glitch: got=%b want=0", bus.ack_err_o); end
        accept(8'h00);
        measure_rts(len);
        device_clock(3, 1'b0, 0, 0, fr);
        total++; if (ps2d !== 1'b0) begin bad++; $display("FAIL middata_ps2d: got=%b want=0", ps2d); end
        reset_i = 1'b1;
        cyc(1);
        reset_i = 1'b0;
        total++; if (ps2d !== 1'b1) begin bad++; $display("FAIL rst_ps2d: got=%b want=released", ps2d); end
        total++; if (ps2c !== 1'b1) begin bad++; $display("FAIL rst_ps2c: got=%b want=released", ps2c); end
        total++; if (bus.tx_idle_o !== 1'b1) begin bad++; $display("FAIL rst_idle: got=%b want=1", bus.tx_idle_o); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        done_cnt      = 0;
        reset_i       = 1'b0;
        dev_c         = 1'b0;
        dev_d         = 1'b0;
        bus.wr_ps2_i  = 1'b0;
        bus.din_i     = 8'h00;
        bus.rx_idle_i = 1'b1;
        cyc(2);
        test_reset;
        test_normal_ack;
        test_missing_ack;
        test_timeout;
        test_blocked_strobes;
        test_glitch_and_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
